// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory port between an instruction-fetch port (i_*) and a data
// port (d_*). Only one access is in flight at a time. Data normally has
// priority. An instruction request that keeps losing is served once the
// starve counter reaches STARVE_MAX. An access that the memory does not
// acknowledge (m_ack_n stays high) is aborted after TIMEOUT cycles, and the
// requesting port then gets an err pulse.
//
// Parameters
//   STARVE_MAX  : data grants allowed while an instruction request waits
//   TIMEOUT     : ack-wait cycles before an access is aborted (must be >= 1)
//   IFETCH_SIZE : m_size code driven for instruction fetches
//
// Ports
//   clk, rst                          : clock, synchronous active-high reset
//   i_req, i_addr                     : instruction fetch request
//   i_rdata, i_ack, i_err             : fetched word, done pulse, timeout pulse
//   d_req, d_write, d_size,
//   d_addr, d_wdata                   : data access request
//   d_rdata, d_ack, d_err             : load data, done pulse, timeout pulse
//   m_req, m_write, m_size,
//   m_addr, m_wdata                   : shared memory request (registered)
//   m_rdata, m_ack_n                  : memory read data, active-low ack
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int         STARVE_MAX  = 4,
    parameter int         TIMEOUT     = 15,
    parameter logic [1:0] IFETCH_SIZE = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack_n
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [SW-1:0]   starve;
    logic [TW-1:0]   tcnt;

    logic starve_full;
    logic i_ok;
    logic d_ok;
    logic d_wins;
    logic grant_d;
    logic grant_i;

    // Arbitration uses the raw requests. A port that is still showing ack/err
    // this cycle may not be granted. If that port is the arbitration winner,
    // the arbiter waits one cycle instead of handing the bus to the loser.
    // This keeps the D/I ratio exact when both requesters hold req high
    // through their acks.
    assign starve_full = (starve == SW'(STARVE_MAX));
    assign i_ok        = i_req && !i_ack && !i_err;
    assign d_ok        = d_req && !d_ack && !d_err;
    assign d_wins      = d_req && !(i_req && starve_full);
    assign grant_d     = d_wins && d_ok;
    assign grant_i     = !d_wins && i_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            starve  <= '0;
            tcnt    <= '0;
            m_req   <= 1'b0;
            m_write <= 1'b0;
            m_size  <= 2'b00;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // branch below reads the values from before this edge. The
            // pulse outputs default low here and are raised only on the
            // cycle they fire.
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= D_ACC;
                        m_req   <= 1'b1;
                        m_addr  <= d_addr;
                        m_size  <= d_size;
                        m_write <= d_write;
                        m_wdata <= d_write ? d_wdata : '0;
                        tcnt    <= '0;
                        if (i_req && !starve_full)
                            starve <= starve + 1'b1;
                    end else if (grant_i) begin
                        state   <= I_ACC;
                        m_req   <= 1'b1;
                        m_addr  <= i_addr;
                        m_size  <= IFETCH_SIZE;
                        m_write <= 1'b0;
                        m_wdata <= '0;
                        tcnt    <= '0;
                        starve  <= '0;
                    end
                end

                I_ACC, D_ACC: begin
                    if (!m_ack_n) begin
                        // An ack on the timeout edge still counts as an ack.
                        state <= IDLE;
                        m_req <= 1'b0;
                        if (state == I_ACC) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!m_write)
                                d_rdata <= m_rdata;
                            d_ack <= 1'b1;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // This edge would take the count to TIMEOUT, so abort.
                        state <= IDLE;
                        m_req <= 1'b0;
                        if (state == I_ACC)
                            i_err <= 1'b1;
                        else
                            d_err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Scoreboard bench for mem_bus_arbiter. Stimulus pushes the expected memory
// grants and port responses into exp_q. A monitor pops and compares them
// whenever the DUT starts a memory access or raises ack/err. A small memory
// responder acks each access after ack_wait cycles.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        m_req;
    logic        m_write;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack_n;

    mem_bus_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_write (d_write),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_write (m_write),
        .m_size  (m_size),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack_n (m_ack_n)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {EV_GRANT, EV_IACK, EV_DACK, EV_IERR, EV_DERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  ack_wait = 0;   // cycles m_req is high before the responder acks

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic [31:0] a, input logic [1:0] s,
                        input logic w, input logic [31:0] wd, input logic [31:0] rd);
        ev_t e;
        e.kind = k; e.addr = a; e.size = s; e.write = w; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_e k, input logic [31:0] a, input logic [1:0] s,
                             input logic w, input logic [31:0] wd, input logic [31:0] rd);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got=%s exp=none", k.name());
        end else begin
            total--;
            e = exp_q.pop_front();
            check({"kind_", e.kind.name()}, 32'(k), 32'(e.kind));
            if (e.kind == EV_GRANT) begin
                check("grant_addr",  a, e.addr);
                check("grant_size",  32'(s), 32'(e.size));
                check("grant_write", 32'(w), 32'(e.write));
                check("grant_wdata", wd, e.wdata);
            end else begin
                check({"rdata_", e.kind.name()}, rd, e.rdata);
            end
        end
    endtask

    // Memory responder: m_ack_n low for exactly the edge ack_wait cycles
    // after the grant (ack_wait = 0 gives the minimum 2-cycle latency).
    int wcyc = 0;
    always @(negedge clk) begin
        if (m_req) begin
            m_ack_n = (wcyc == ack_wait) ? 1'b0 : 1'b1;
            wcyc++;
        end else begin
            m_ack_n = 1'b1;
            wcyc = 0;
        end
    end

    // Monitor: compares every grant and response against the scoreboard and
    // checks that the request fields stay stable during an access.
    logic        prev_mreq = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [2:0]  held_ctl;
    always @(negedge clk) begin : monitor
        int n;
        if (!rst) begin
            n = int'(i_ack) + int'(i_err) + int'(d_ack) + int'(d_err);
            if (n != 0) check("one_response", 32'(n), 32'd1);
            if (i_ack) pop_check(EV_IACK, 0, 0, 0, 0, i_rdata);
            if (i_err) pop_check(EV_IERR, 0, 0, 0, 0, i_rdata);
            if (d_ack) pop_check(EV_DACK, 0, 0, 0, 0, d_rdata);
            if (d_err) pop_check(EV_DERR, 0, 0, 0, 0, d_rdata);
            if (m_req && !prev_mreq) begin
                pop_check(EV_GRANT, m_addr, m_size, m_write, m_wdata, 0);
                held_addr  = m_addr;
                held_wdata = m_wdata;
                held_ctl   = {m_size, m_write};
            end else if (m_req) begin
                check("hold_addr",  m_addr, held_addr);
                check("hold_wdata", m_wdata, held_wdata);
                check("hold_ctl",   32'({m_size, m_write}), 32'(held_ctl));
            end
        end
        prev_mreq = m_req;
    end

    // Raise the requested ports and serve them as a requester would: each
    // port keeps req high until it has seen n responses, then drops it.
    task automatic run_access(input int n_i, input int n_d, input int budget);
        int ci = 0;
        int cd = 0;
        int cyc = 0;
        @(negedge clk);
        if (n_i > 0) i_req = 1'b1;
        if (n_d > 0) d_req = 1'b1;
        while ((ci < n_i || cd < n_d) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (i_ack || i_err) ci++;
            if (d_ack || d_err) cd++;
            if (ci >= n_i) i_req = 1'b0;
            if (cd >= n_d) d_req = 1'b0;
        end
        check("responses_seen", 32'(ci + cd), 32'(n_i + n_d));
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Single data access; returns the number of negedges from the grant
    // edge to the response.
    task automatic single_d(output int k, output logic saw_err);
        k = 0;
        saw_err = 1'b0;
        @(negedge clk);
        d_req = 1'b1;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (d_ack || d_err) begin
                saw_err = d_err;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    initial begin
        int   k;
        logic e;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
        d_size = 2'b00; d_addr = '0; d_wdata = '0; m_rdata = '0; m_ack_n = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_m_req",   32'(m_req), 0);
        check("rst_m_addr",  m_addr, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_resp",    32'({i_ack, i_err, d_ack, d_err}), 0);
        rst = 1'b0;

        // Single fetch at minimum latency.
        ack_wait = 0;
        m_rdata  = 32'h8C01_0004;
        i_addr   = 32'h0000_0100;
        push(EV_GRANT, 32'h100, 2'b00, 1'b0, 0, 0);
        push(EV_IACK,  0, 0, 0, 0, 32'h8C01_0004);
        @(negedge clk);
        i_req = 1'b1;
        @(negedge clk);
        check("lat_m_req_on", 32'(m_req), 1);
        @(negedge clk);
        check("lat_m_req_off", 32'(m_req), 0);
        check("lat_i_ack",     32'(i_ack), 1);
        i_req = 1'b0;
        @(negedge clk);
        check("i_ack_one_cycle", 32'(i_ack), 0);

        // Both request: data write first, then the fetch. A write leaves
        // d_rdata at its reset value.
        m_rdata = 32'h1234_5678;
        i_addr  = 32'h0000_0104;
        d_write = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_size = 2'b01;
        push(EV_GRANT, 32'h2000, 2'b01, 1'b1, 32'hDEAD_BEEF, 0);
        push(EV_DACK,  0, 0, 0, 0, 32'h0);
        push(EV_GRANT, 32'h104, 2'b00, 1'b0, 0, 0);
        push(EV_IACK,  0, 0, 0, 0, 32'h1234_5678);
        run_access(1, 1, 40);

        // Both held continuously: D D D D I D D D D I.
        m_rdata = 32'hCAFE_0001;
        i_addr  = 32'h0000_0200;
        d_write = 1'b0; d_addr = 32'h3000; d_wdata = 32'h5555_AAAA; d_size = 2'b10;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                push(EV_GRANT, 32'h3000, 2'b10, 1'b0, 0, 0);
                push(EV_DACK,  0, 0, 0, 0, 32'hCAFE_0001);
            end
            push(EV_GRANT, 32'h200, 2'b00, 1'b0, 0, 0);
            push(EV_IACK,  0, 0, 0, 0, 32'hCAFE_0001);
        end
        run_access(2, 8, 200);

        // Timeout: no ack, d_err 15 edges after the grant, d_rdata kept.
        ack_wait = 100;
        d_addr   = 32'h4000;
        push(EV_GRANT, 32'h4000, 2'b10, 1'b0, 0, 0);
        push(EV_DERR,  0, 0, 0, 0, 32'hCAFE_0001);
        single_d(k, e);
        check("timeout_latency", 32'(k), 32'd16);
        check("timeout_is_err",  32'(e), 1);

        // Ack on the timeout edge wins.
        ack_wait = 14;
        m_rdata  = 32'h0BAD_F00D;
        push(EV_GRANT, 32'h4000, 2'b10, 1'b0, 0, 0);
        push(EV_DACK,  0, 0, 0, 0, 32'h0BAD_F00D);
        single_d(k, e);
        check("late_ack_latency", 32'(k), 32'd16);
        check("late_ack_not_err", 32'(e), 0);

        // Reset in the middle of a data access.
        ack_wait = 100;
        d_addr   = 32'h5000;
        push(EV_GRANT, 32'h5000, 2'b10, 1'b0, 0, 0);
        @(negedge clk);
        d_req = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_inflight", 32'(m_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_m_req",   32'(m_req), 0);
        check("abort_m_addr",  m_addr, 0);
        check("abort_resp",    32'({d_ack, d_err}), 0);
        check("abort_d_rdata", d_rdata, 0);
        d_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_resp", 32'({i_ack, i_err, d_ack, d_err}), 0);

        // Normal fetch after reset release.
        ack_wait = 0;
        m_rdata  = 32'h1111_2222;
        i_addr   = 32'h0000_0600;
        push(EV_GRANT, 32'h600, 2'b00, 1'b0, 0, 0);
        push(EV_IACK,  0, 0, 0, 0, 32'h1111_2222);
        run_access(1, 0, 20);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: ack-wait cycles before a bus-error abort.
REQ-003 SHALL have parameter IFETCH_SIZE, default 2'b00: m_size code driven for instruction fetches.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_req in 1, i_addr in 32: instruction fetch request and address.
REQ-007 SHALL have ports i_rdata out 32, i_ack out 1, i_err out 1: fetched word, completion pulse, timeout pulse.
REQ-008 SHALL have ports d_req in 1, d_write in 1, d_size in 2, d_addr in 32, d_wdata in 32: data access request.
REQ-009 SHALL have ports d_rdata out 32, d_ack out 1, d_err out 1: load data, completion pulse, timeout pulse.
REQ-010 SHALL have ports m_req out 1, m_write out 1, m_size out 2, m_addr out 32, m_wdata out 32: shared memory port.
REQ-011 SHALL have ports m_rdata in 32, m_ack_n in 1: memory read data and active-low acknowledge.

Function
REQ-012 SHALL implement FSM states IDLE, I_ACC, D_ACC; m_req = 1 exactly when state is I_ACC or D_ACC.
REQ-013 In IDLE, at a clock edge with a valid request, SHALL grant:
- d_req alone -> D_ACC
- i_req alone -> I_ACC
- both pending -> D_ACC, unless starve count equals STARVE_MAX, then I_ACC
REQ-014 Starve counter SHALL increment on each D grant made while i_req = 1, clear on each I grant, and saturate at STARVE_MAX.
REQ-015 On grant, SHALL register m_addr, m_size, m_write and m_wdata from the winning port, and hold them stable until the access ends.
- I grant: m_size = IFETCH_SIZE, m_write = 0
- D grant: d_size, d_write
- m_wdata = d_wdata only for a D write, else 0
REQ-016 In I_ACC/D_ACC, at an edge with m_ack_n = 0, SHALL:
- latch m_rdata into the granted port's rdata (reads only)
- pulse that port's ack high for exactly one cycle
- return to IDLE
REQ-017 Minimum latency SHALL be 2 cycles: request sampled at edge N -> m_req high in cycle N..N+1 -> ack high in cycle N+1..N+2 when m_ack_n = 0 at edge N+1.
REQ-018 A port's req SHALL be ignored in any cycle in which that port's ack or err is high; the same port can be re-granted no earlier than the following edge.
REQ-019 A timeout counter SHALL clear on grant and increment each cycle in I_ACC/D_ACC with m_ack_n = 1. When it reaches TIMEOUT, the FSM SHALL:
- pulse the granted port's err for one cycle
- leave its rdata unchanged
- issue no ack
- return to IDLE
REQ-020 m_ack_n = 0 on the same edge the counter reaches TIMEOUT SHALL be treated as a normal ack (ack wins over err).
REQ-021 m_ack_n SHALL be ignored in IDLE.
REQ-022 i_rdata/d_rdata SHALL hold their last value between accesses; a D write SHALL leave d_rdata unchanged.
REQ-023 ack and err SHALL never be high together, and never on both ports in the same cycle.

Reset
REQ-024 While rst = 1 at an edge, SHALL force:
- state IDLE
- m_req, m_write, m_size = 0; m_addr, m_wdata = 0
- i_rdata, d_rdata = 0; all ack/err = 0
- starve and timeout counters = 0
REQ-025 rst asserted mid-access SHALL drop m_req at that edge with no ack or err pulse for the aborted access.

Verification
REQ-026 i_req = 1, i_addr = 0x00000100, m_ack_n low at first access edge, m_rdata = 0x8C010004 -> m_req high 1 cycle, m_addr = 0x100, m_size = IFETCH_SIZE, i_ack pulse, i_rdata = 0x8C010004.
REQ-027 i_req and d_req both high, d_write = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, d_size = 2'b01 -> data granted first with m_write = 1, m_wdata = 0xDEADBEEF, m_size = 2'b01; instruction granted next; d_rdata unchanged.
REQ-028 Both requesters held continuously, memory acks every access -> exactly 4 D grants then 1 I grant, pattern repeating.
REQ-029 d_req = 1, m_ack_n held high -> d_err pulse when the timeout counter reaches 15 after grant, no d_ack, FSM back in IDLE; repeat with m_ack_n = 0 on that edge -> d_ack, no d_err.
REQ-030 rst = 1 during D_ACC -> next cycle m_req = 0, m_addr = 0, d_ack = d_err = 0; after rst release, a pending i_req is granted normally.
